// File: rtl/command_dispatcher_if.sv
// command_dispatcher_if: FIFO read port and command beat port of the command dispatcher
interface command_dispatcher_if #(
    parameter int ADDR_W = 16,
    parameter int ERR_W  = 8
);
    logic              fifo_empty;
    logic [31:0]       read_data;
    logic              read_command;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_data;
    logic              cmd_error;
    logic [ERR_W-1:0]  err_count;
    logic              busy;

    modport master (
        input  fifo_empty, read_data, cmd_ready,
        output read_command, cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_error, err_count, busy
    );

    modport slave (
        output fifo_empty, read_data, cmd_ready,
        input  read_command, cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_error, err_count, busy
    );
endinterface

// File: rtl/command_dispatcher.sv
// command_dispatcher: pops header/payload words from the command FIFO, validates them and issues
// single-beat commands; bursts are expanded into consecutive-address beats.
// Optional: define CMD_PARITY_CHECK_EN to reject headers whose 32 bits do not have odd parity.
module command_dispatcher #(
    parameter int ADDR_W = 16,
    parameter int ERR_W  = 8
) (
    input  logic clk,
    input  logic n_rst,
    command_dispatcher_if.master bus
);
    typedef enum logic [2:0] {IDLE, DECODE, ERROR, WAIT_DATA, ISSUE} state_t;

    state_t            state, next;
    logic [3:0]        opcode, len, remaining;
    logic [ADDR_W-1:0] hdr_addr, addr_q;
    logic [31:0]       data_q;
    logic              write_q;
    logic [ERR_W-1:0]  err_q;
    logic              pop, fire, parity_ok, illegal;

    assign pop     = !bus.fifo_empty && (state == IDLE || state == WAIT_DATA);
    assign fire    = state == ISSUE && bus.cmd_ready;
    assign illegal = !parity_ok || opcode > 4'd3;

`ifdef CMD_PARITY_CHECK_EN
    logic hdr_odd;
    // Parity is reduced while the header is on the bus so the full word need not be stored
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) hdr_odd <= 1'b0;
        else if (state == IDLE && pop) hdr_odd <= ^bus.read_data;
    end
    assign parity_ok = hdr_odd;
`else
    assign parity_ok = 1'b1;
`endif

    assign bus.read_command = pop;
    assign bus.cmd_valid    = state == ISSUE;
    assign bus.cmd_error    = state == ERROR;
    assign bus.busy         = state != IDLE;
    assign bus.cmd_write    = write_q;
    assign bus.cmd_addr     = addr_q;
    assign bus.cmd_data     = data_q;
    assign bus.err_count    = err_q;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else state <= next;
    end

    // Next-state decode
    always_comb begin
        next = state;
        case (state)
            IDLE:      if (pop) next = DECODE;
            DECODE:    next = illegal ? ERROR : opcode == 4'd0 ? IDLE : opcode == 4'd2 ? ISSUE : WAIT_DATA;
            ERROR:     next = IDLE;
            WAIT_DATA: if (pop) next = ISSUE;
            ISSUE:     if (fire) next = remaining != 4'd0 ? WAIT_DATA : IDLE;
            default:   next = IDLE;
        endcase
    end

    // Header capture, beat fields, burst bookkeeping and saturating error count
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            opcode    <= '0;
            len       <= '0;
            hdr_addr  <= '0;
            remaining <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            if (state == IDLE && pop) begin
                opcode   <= bus.read_data[31:28];
                len      <= bus.read_data[27:24];
                hdr_addr <= bus.read_data[ADDR_W-1:0];
            end
            if (state == DECODE) begin
                addr_q    <= hdr_addr;
                write_q   <= opcode != 4'd2;
                data_q    <= '0;
                remaining <= opcode == 4'd3 ? len : 4'd0;
            end
            if (state == WAIT_DATA && pop) data_q <= bus.read_data;
            if (fire && remaining != 4'd0) begin
                addr_q    <= addr_q + ADDR_W'(1);
                remaining <= remaining - 4'd1;
            end
            if (state == ERROR && !(&err_q)) err_q <= err_q + ERR_W'(1);
        end
    end
endmodule
